// File: rtl/avalon_mm_arbiter_pkg.sv
// Shared types for the two-host Avalon-MM arbiter: data width, FSM states, bus owner,
// and the tie-break rule used in IDLE.
package Types;

   typedef logic [31:0] uint32_t;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_INS,
      GRANT_DAT,
      WAIT_RD
   } arb_state_t;

   typedef enum logic {
      OWNER_INS,
      OWNER_DAT
   } arb_owner_t;

   // On a tie, round-robin hands the bus to whoever did not have it last;
   // fixed priority always favours the data host.
   function automatic arb_owner_t pick_owner(input logic       ins_req,
                                             input logic       dat_req,
                                             input arb_owner_t last_grant,
                                             input logic       fair);
      arb_owner_t winner;
      winner = OWNER_INS;
      if (ins_req && dat_req) begin
         if (fair)
            winner = (last_grant == OWNER_DAT) ? OWNER_INS : OWNER_DAT;
         else
            winner = OWNER_DAT;
      end else if (dat_req) begin
         winner = OWNER_DAT;
      end
      return winner;
   endfunction

endpackage

// File: rtl/avalon_mm_arbiter.sv
// Arbitrates an instruction host and a data host onto one Avalon-MM memory agent,
// with at most one transaction in flight.
module avalon_mm_arbiter
   import Types::*;
#(
   parameter bit FAIR = 1'b1
) (
   input  logic          clk,
   input  logic          rst,

   input  uint32_t       ins_address,
   input  logic [3:0]    ins_byteenable,
   input  logic          ins_read,
   output logic          ins_waitrequest,
   output uint32_t       ins_agent_to_host,
   output logic          ins_readdatavalid,

   input  uint32_t       dat_address,
   input  logic [3:0]    dat_byteenable,
   input  logic          dat_read,
   input  logic          dat_write,
   input  uint32_t       dat_host_to_agent,
   output logic          dat_waitrequest,
   output uint32_t       dat_agent_to_host,
   output logic          dat_readdatavalid,

   output uint32_t       mem_address,
   output logic [3:0]    mem_byteenable,
   output logic          mem_read,
   output logic          mem_write,
   output uint32_t       mem_host_to_agent,
   input  logic          mem_waitrequest,
   input  uint32_t       mem_agent_to_host,
   input  logic          mem_readdatavalid
);

   arb_state_t state;
   arb_owner_t owner;
   arb_owner_t last_grant;
   arb_owner_t winner;

   logic grant_ins;
   logic grant_dat;
   logic owner_read;
   logic owner_write;
   logic dat_req;

   // A simultaneous read and write from the data host is served as a read.
   assign dat_req     = dat_read | dat_write;
   assign grant_ins   = (state == GRANT_INS);
   assign grant_dat   = (state == GRANT_DAT);
   assign owner_read  = (grant_ins & ins_read) | (grant_dat & dat_read);
   assign owner_write = grant_dat & dat_write & ~dat_read;
   assign winner      = pick_owner(ins_read, dat_req, last_grant, FAIR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= OWNER_INS;
         last_grant <= OWNER_DAT;
      end else begin
         unique case (state)
            IDLE: begin
               if (ins_read || dat_req) begin
                  owner      <= winner;
                  last_grant <= winner;
                  state      <= (winner == OWNER_DAT) ? GRANT_DAT : GRANT_INS;
               end
            end
            GRANT_INS, GRANT_DAT: begin
               if (!(owner_read || owner_write))
                  state <= IDLE;
               else if (!mem_waitrequest)
                  state <= owner_read ? WAIT_RD : IDLE;
            end
            WAIT_RD: begin
               if (mem_readdatavalid)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Command port follows the granted host combinationally; idle and read-wait drive nothing.
   assign mem_read          = owner_read;
   assign mem_write         = owner_write;
   assign mem_address       = grant_dat ? dat_address    : (grant_ins ? ins_address    : '0);
   assign mem_byteenable    = grant_dat ? dat_byteenable : (grant_ins ? ins_byteenable : '0);
   assign mem_host_to_agent = grant_dat ? dat_host_to_agent : '0;

   assign ins_waitrequest   = grant_ins ? mem_waitrequest : 1'b1;
   assign dat_waitrequest   = grant_dat ? mem_waitrequest : 1'b1;

   assign ins_agent_to_host = mem_agent_to_host;
   assign dat_agent_to_host = mem_agent_to_host;
   assign ins_readdatavalid = (state == WAIT_RD) && (owner == OWNER_INS) && mem_readdatavalid;
   assign dat_readdatavalid = (state == WAIT_RD) && (owner == OWNER_DAT) && mem_readdatavalid;

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Scoreboard bench for avalon_mm_arbiter: a round-based reference model predicts the
// order of memory commands and read data; a monitor compares what the DUT presents.
module tb_avalon_mm_arbiter;
   import Types::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uint32_t    ins_address, dat_address, dat_host_to_agent;
   logic [3:0] ins_byteenable, dat_byteenable;
   logic       ins_read, dat_read, dat_write;
   logic       ins_waitrequest, ins_readdatavalid, dat_waitrequest, dat_readdatavalid;
   uint32_t    ins_agent_to_host, dat_agent_to_host;
   uint32_t    mem_address, mem_host_to_agent, mem_agent_to_host;
   logic [3:0] mem_byteenable;
   logic       mem_read, mem_write, mem_waitrequest, mem_readdatavalid;

   avalon_mm_arbiter #(.FAIR(1'b1)) dut (
      .clk(clk), .rst(rst),
      .ins_address(ins_address), .ins_byteenable(ins_byteenable), .ins_read(ins_read),
      .ins_waitrequest(ins_waitrequest), .ins_agent_to_host(ins_agent_to_host),
      .ins_readdatavalid(ins_readdatavalid),
      .dat_address(dat_address), .dat_byteenable(dat_byteenable), .dat_read(dat_read),
      .dat_write(dat_write), .dat_host_to_agent(dat_host_to_agent),
      .dat_waitrequest(dat_waitrequest), .dat_agent_to_host(dat_agent_to_host),
      .dat_readdatavalid(dat_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read),
      .mem_write(mem_write), .mem_host_to_agent(mem_host_to_agent),
      .mem_waitrequest(mem_waitrequest), .mem_agent_to_host(mem_agent_to_host),
      .mem_readdatavalid(mem_readdatavalid)
   );

   // Second instance with fixed priority, used for the data-wins tie case.
   uint32_t    f0_ins_address, f0_dat_address, f0_dat_host_to_agent;
   logic [3:0] f0_ins_byteenable, f0_dat_byteenable;
   logic       f0_ins_read, f0_dat_read, f0_dat_write;
   logic       f0_ins_waitrequest, f0_ins_readdatavalid, f0_dat_waitrequest, f0_dat_readdatavalid;
   uint32_t    f0_ins_agent_to_host, f0_dat_agent_to_host;
   uint32_t    f0_mem_address, f0_mem_host_to_agent, f0_mem_agent_to_host;
   logic [3:0] f0_mem_byteenable;
   logic       f0_mem_read, f0_mem_write, f0_mem_waitrequest, f0_mem_readdatavalid;

   avalon_mm_arbiter #(.FAIR(1'b0)) dut_fixed (
      .clk(clk), .rst(rst),
      .ins_address(f0_ins_address), .ins_byteenable(f0_ins_byteenable), .ins_read(f0_ins_read),
      .ins_waitrequest(f0_ins_waitrequest), .ins_agent_to_host(f0_ins_agent_to_host),
      .ins_readdatavalid(f0_ins_readdatavalid),
      .dat_address(f0_dat_address), .dat_byteenable(f0_dat_byteenable), .dat_read(f0_dat_read),
      .dat_write(f0_dat_write), .dat_host_to_agent(f0_dat_host_to_agent),
      .dat_waitrequest(f0_dat_waitrequest), .dat_agent_to_host(f0_dat_agent_to_host),
      .dat_readdatavalid(f0_dat_readdatavalid),
      .mem_address(f0_mem_address), .mem_byteenable(f0_mem_byteenable), .mem_read(f0_mem_read),
      .mem_write(f0_mem_write), .mem_host_to_agent(f0_mem_host_to_agent),
      .mem_waitrequest(f0_mem_waitrequest), .mem_agent_to_host(f0_mem_agent_to_host),
      .mem_readdatavalid(f0_mem_readdatavalid)
   );

   typedef struct {
      bit         host_dat;
      bit         wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } cmd_t;

   cmd_t        cmd_q[$];
   logic [31:0] ins_q[$];
   logic [31:0] dat_q[$];

   int checks = 0;
   int failures = 0;
   bit sb_en = 1'b0;
   int ins_grants = 0, dat_grants = 0, stall_seen = 0;
   bit model_last_dat = 1'b1;

   bit stall_en = 1'b0, spur_en = 1'b0, rd_lat_rand = 1'b0;
   int rd_lat = 2;
   int stall_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] agent_data(input logic [31:0] addr);
      if (addr == 32'h0000_0010) return 32'hDEAD_BEEF;
      return {addr[15:0], ~addr[15:0]} ^ 32'h3C3C_0000;
   endfunction

   // Memory agent: random stalls, 1..3 cycle read latency, optional stray readdatavalid.
   initial begin : agent
      logic        acc;
      logic [31:0] acc_addr, pend;
      int          rd_cnt;
      rd_cnt = 0;
      pend = '0;
      mem_waitrequest = 1'b0;
      mem_readdatavalid = 1'b0;
      mem_agent_to_host = '0;
      forever begin
         @(negedge clk);
         acc = mem_read && !mem_waitrequest && !rst;
         acc_addr = mem_address;
         @(posedge clk);
         #2;
         mem_readdatavalid = 1'b0;
         mem_agent_to_host = $urandom;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               mem_readdatavalid = 1'b1;
               mem_agent_to_host = pend;
            end
         end else if (spur_en && !acc && $urandom_range(0, 7) == 0) begin
            mem_readdatavalid = 1'b1;
         end
         if (acc) begin
            rd_cnt = rd_lat_rand ? int'($urandom_range(1, 3)) : rd_lat;
            pend = agent_data(acc_addr);
         end
         if (stall_left > 0 && (mem_read || mem_write)) begin
            mem_waitrequest = 1'b1;
            stall_left--;
         end else begin
            mem_waitrequest = stall_en && ($urandom_range(0, 3) == 0);
         end
      end
   end

   // Monitor: compares every presented command and every read response with the queues.
   initial begin : monitor
      cmd_t e;
      logic [31:0] d;
      forever begin
         @(negedge clk);
         if (sb_en && !rst) begin
            if (mem_read || mem_write) begin
               if (cmd_q.size() == 0) begin
                  check("cmd_unexpected", {30'd0, mem_read, mem_write}, 32'd0);
               end else begin
                  e = cmd_q[0];
                  check("cmd_addr", mem_address, e.addr);
                  check("cmd_be", {28'd0, mem_byteenable}, {28'd0, e.be});
                  check("cmd_rw", {30'd0, mem_read, mem_write}, {30'd0, !e.wr, e.wr});
                  if (e.wr) check("cmd_wdata", mem_host_to_agent, e.wdata);
                  check("owner_wait", {31'd0, e.host_dat ? dat_waitrequest : ins_waitrequest},
                        {31'd0, mem_waitrequest});
                  check("other_wait", {31'd0, e.host_dat ? ins_waitrequest : dat_waitrequest}, 32'd1);
                  if (!mem_waitrequest) begin
                     void'(cmd_q.pop_front());
                     if (e.host_dat) dat_grants++; else ins_grants++;
                     $display("txn %s %s addr=0x%08h data=0x%08h", e.host_dat ? "dat" : "ins",
                              e.wr ? "write" : "read", e.addr, e.wdata);
                  end else begin
                     stall_seen++;
                  end
               end
            end
            if (ins_readdatavalid) begin
               if (ins_q.size() == 0) check("ins_rdv_unexpected", 32'd1, 32'd0);
               else begin
                  d = ins_q.pop_front();
                  check("ins_rdata", ins_agent_to_host, d);
               end
            end
            if (dat_readdatavalid) begin
               if (dat_q.size() == 0) check("dat_rdv_unexpected", 32'd1, 32'd0);
               else begin
                  d = dat_q.pop_front();
                  check("dat_rdata", dat_agent_to_host, d);
               end
            end
         end
      end
   end

   task automatic ins_host(input logic [31:0] addr, input logic [3:0] be);
      int n;
      n = 0;
      ins_address = addr;
      ins_byteenable = be;
      ins_read = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (ins_waitrequest && n < 200);
      check("ins_accept", {31'd0, ins_waitrequest}, 32'd0);
      @(posedge clk);
      #1;
      ins_read = 1'b0;
   endtask

   task automatic dat_host(input logic [31:0] addr, input logic [3:0] be,
                           input bit rd, input bit wr, input logic [31:0] wdata);
      int n;
      n = 0;
      dat_address = addr;
      dat_byteenable = be;
      dat_host_to_agent = wdata;
      dat_read = rd;
      dat_write = wr;
      do begin
         @(negedge clk);
         n++;
      end while (dat_waitrequest && n < 200);
      check("dat_accept", {31'd0, dat_waitrequest}, 32'd0);
      @(posedge clk);
      #1;
      dat_read = 1'b0;
      dat_write = 1'b0;
   endtask

   // One round: each host optionally issues one request in the same cycle; the model
   // serves the tie winner first, then the other, and remembers who was served last.
   task automatic run_round(input bit ie, input logic [31:0] ia, input logic [3:0] ib,
                            input bit de, input bit drd, input bit dwr,
                            input logic [31:0] da, input logic [3:0] db, input logic [31:0] dd);
      cmd_t ci, cd;
      int   n;
      ci = '{host_dat: 1'b0, wr: 1'b0, addr: ia, be: ib, wdata: 32'd0};
      cd = '{host_dat: 1'b1, wr: dwr && !drd, addr: da, be: db, wdata: dd};
      if (ie && de) begin
         if (model_last_dat) begin
            cmd_q.push_back(ci); cmd_q.push_back(cd); model_last_dat = 1'b1;
         end else begin
            cmd_q.push_back(cd); cmd_q.push_back(ci); model_last_dat = 1'b0;
         end
      end else if (ie) begin
         cmd_q.push_back(ci); model_last_dat = 1'b0;
      end else if (de) begin
         cmd_q.push_back(cd); model_last_dat = 1'b1;
      end
      if (ie) ins_q.push_back(agent_data(ia));
      if (de && !cd.wr) dat_q.push_back(agent_data(da));
      @(posedge clk);
      #1;
      fork
         if (ie) ins_host(ia, ib);
         if (de) dat_host(da, db, drd, dwr, dd);
      join
      n = 0;
      while ((cmd_q.size() + ins_q.size() + dat_q.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("round_drain", cmd_q.size() + ins_q.size() + dat_q.size(), 32'd0);
      cmd_q.delete(); ins_q.delete(); dat_q.delete();
   endtask

   initial begin : main
      int  n;
      bit  hit;
      bit  rd, wr;
      ins_address = '0; ins_byteenable = '0; ins_read = 1'b0;
      dat_address = '0; dat_byteenable = '0; dat_read = 1'b0; dat_write = 1'b0;
      dat_host_to_agent = '0;
      f0_ins_address = '0; f0_ins_byteenable = '0; f0_ins_read = 1'b0;
      f0_dat_address = '0; f0_dat_byteenable = '0; f0_dat_read = 1'b0; f0_dat_write = 1'b0;
      f0_dat_host_to_agent = '0; f0_mem_waitrequest = 1'b0;
      f0_mem_agent_to_host = '0; f0_mem_readdatavalid = 1'b0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ins_wait", {31'd0, ins_waitrequest}, 32'd1);
      check("rst_dat_wait", {31'd0, dat_waitrequest}, 32'd1);
      check("rst_mem_cmd", {30'd0, mem_read, mem_write}, 32'd0);
      check("rst_rdv", {30'd0, ins_readdatavalid, dat_readdatavalid}, 32'd0);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b0;
      model_last_dat = 1'b1;
      sb_en = 1'b1;

      // Tie straight after reset: instruction first, then the data write.
      run_round(1'b1, 32'h100, 4'hF, 1'b1, 1'b0, 1'b1, 32'h200, 4'hF, 32'h1234_5678);
      // Instruction read alone with two-cycle agent latency.
      rd_lat = 2;
      run_round(1'b1, 32'h10, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      // Agent stalls a data read for three cycles.
      stall_seen = 0;
      stall_left = 3;
      run_round(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h300, 4'h3, 32'h0);
      check("stall_cycles", stall_seen, 32'd3);

      // Fixed-priority instance: the data write goes first on a tie.
      @(posedge clk);
      #1;
      f0_ins_address = 32'h100; f0_ins_byteenable = 4'hF; f0_ins_read = 1'b1;
      f0_dat_address = 32'h200; f0_dat_byteenable = 4'hF; f0_dat_write = 1'b1;
      f0_dat_host_to_agent = 32'h1234_5678;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(f0_mem_read || f0_mem_write) && n < 10);
      check("fixed_first_write", {30'd0, f0_mem_read, f0_mem_write}, 32'd1);
      check("fixed_first_addr", f0_mem_address, 32'h200);
      check("fixed_first_wdata", f0_mem_host_to_agent, 32'h1234_5678);
      @(posedge clk);
      #1;
      f0_ins_read = 1'b0; f0_dat_write = 1'b0;

      // Starvation: 20 back-to-back contended transactions alternate hosts.
      ins_grants = 0;
      dat_grants = 0;
      for (int r = 0; r < 10; r++) begin
         rd = ($urandom_range(0, 1) == 1);
         run_round(1'b1, 32'h1000 + 32'(r * 4), 4'hF, 1'b1, rd, !rd,
                   32'h2000 + 32'(r * 4), 4'hF, $urandom);
      end
      check("starve_ins", ins_grants, 32'd10);
      check("starve_dat", dat_grants, 32'd10);

      // Randomized rounds with stalls, variable latency and stray readdatavalid.
      stall_en = 1'b1;
      spur_en = 1'b1;
      rd_lat_rand = 1'b1;
      for (int r = 0; r < 150; r++) begin
         rd = ($urandom_range(0, 1) == 1);
         wr = ($urandom_range(0, 4) == 0) ? 1'b1 : !rd;
         run_round($urandom_range(0, 2) != 0, {$urandom_range(0, 65535), 2'b00},
                   4'($urandom_range(1, 15)), $urandom_range(0, 2) != 0, rd, wr,
                   {$urandom_range(0, 65535), 2'b00}, 4'($urandom_range(1, 15)), $urandom);
      end

      // Reset while waiting for read data: the late response must be dropped.
      sb_en = 1'b0;
      stall_en = 1'b0;
      spur_en = 1'b0;
      rd_lat_rand = 1'b0;
      rd_lat = 3;
      repeat (4) @(posedge clk);
      #1;
      ins_address = 32'h40; ins_byteenable = 4'hF; ins_read = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ins_waitrequest && n < 20);
      check("midrd_accept", {31'd0, ins_waitrequest}, 32'd0);
      @(posedge clk);
      #1;
      ins_read = 1'b0;
      check("midrd_in_wait", 32'(dut.state), 32'(WAIT_RD));
      rst = 1'b1;
      #1;
      check("midrd_async_idle", 32'(dut.state), 32'(IDLE));
      @(posedge clk);
      #1;
      rst = 1'b0;
      hit = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ins_readdatavalid || dat_readdatavalid) hit = 1'b1;
      end
      check("midrd_no_rdv", {31'd0, hit}, 32'd0);
      check("midrd_idle", 32'(dut.state), 32'(IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
